// File: rtl/mem_copy_dma.sv
// Memory-to-memory copy engine: one read then one write per word over the on-chip memory port.
// Define MEM_DMA_TIMEOUT_EN to abort a copy when ready stays low for TIMEOUT_CYCLES.
module mem_copy_dma #(
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  mem_enable,
    output logic                  mem_write,
    input  logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] src_reg, dst_reg, buf_reg;
    logic [LEN_WIDTH-1:0]  len_reg, idx_reg;
    logic                  ready_ok, last_word, in_xfer, timeout_hit;

    // X or Z on ready must read as "not ready"
    assign ready_ok  = (mem_ready == 1'b1);
    assign last_word = (idx_reg == len_reg - LEN_WIDTH'(1));
    assign in_xfer   = (state_reg == ST_READ) || (state_reg == ST_WRITE);

`ifdef MEM_DMA_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_WIDTH-1:0] wait_cnt_reg;
    logic                 error_reg;

    assign timeout_hit = in_xfer && !ready_ok &&
                         (wait_cnt_reg == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    // Counter is held at zero outside READ/WRITE, so every entry starts fresh
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wait_cnt_reg <= '0;
        end else if (!in_xfer || ready_ok) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_reg + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            error_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && start) begin
            error_reg <= 1'b0;
        end else if (timeout_hit) begin
            error_reg <= 1'b1;
        end
    end

    assign error = error_reg;
`else
    // Only the watchdog build consumes TIMEOUT_CYCLES
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (timeout_hit) begin
                    state_next = ST_DONE;
                end else if (ready_ok) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (timeout_hit) begin
                    state_next = ST_DONE;
                end else if (ready_ok) begin
                    state_next = last_word ? ST_DONE : ST_READ;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            src_reg <= '0;
            dst_reg <= '0;
            len_reg <= '0;
            idx_reg <= '0;
            buf_reg <= '0;
        end else begin
            if (state_reg == ST_IDLE && start) begin
                src_reg <= src_addr;
                dst_reg <= dst_addr;
                len_reg <= len;
                idx_reg <= '0;
            end
            if (state_reg == ST_READ && ready_ok) begin
                buf_reg <= mem_rdata;
            end
            // Index only advances when another word follows
            if (state_reg == ST_WRITE && ready_ok && !last_word) begin
                idx_reg <= idx_reg + LEN_WIDTH'(1);
            end
        end
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        mem_enable = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_reg)
            ST_READ: begin
                busy       = 1'b1;
                mem_enable = 1'b1;
                mem_addr   = src_reg + DATA_WIDTH'(idx_reg);
            end
            ST_WRITE: begin
                busy       = 1'b1;
                mem_enable = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = dst_reg + DATA_WIDTH'(idx_reg);
                mem_wdata  = buf_reg;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/mem_copy_dma.md
Name: mem_copy_dma

Overview:
- Bus initiator for the on-chip memory port (enable / write / ready / addr / wdata / rdata); drives that port from the master side.
- Copies LEN consecutive words from SRC to DST, one read followed by one write per word.
- Used to move firmware/profile tables between memory instances (e.g. ROM image to working RAM) without CPU involvement.

Parameters:
- DATA_WIDTH, 32, width of the address and data buses; matches the memory port.
- LEN_WIDTH, 16, width of the word-count input and the internal index counter.
- TIMEOUT_CYCLES, 64, cycles to wait for ready before aborting (used only with MEM_DMA_TIMEOUT_EN).

Ports:
- clk_in  input  1  system clock; all logic on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- start  input  1  request a copy; sampled only in IDLE.
- src_addr  input  DATA_WIDTH  first source word address; captured on accepted start.
- dst_addr  input  DATA_WIDTH  first destination word address; captured on accepted start.
- len  input  LEN_WIDTH  number of words to copy; captured on accepted start.
- busy  output  1  high in READ and WRITE.
- done  output  1  one-cycle pulse when a copy finishes or aborts.
- error  output  1  sticky abort flag; cleared on the next accepted start or reset.
- mem_enable  output  1  memory port enable.
- mem_write  output  1  memory port write strobe.
- mem_ready  input  1  memory ready; only logic 1 counts as ready (0, Z and X mean not ready).
- mem_addr  output  DATA_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  write data.
- mem_rdata  input  DATA_WIDTH  read data; valid while mem_enable is high and mem_ready is 1.

Behaviour:
- Clock and reset:
  - One clock, clk_in. Reset is synchronous and active-high on rst_in.
  - On reset: state=IDLE, and busy, done, error, mem_enable, mem_write are all 0. mem_addr, mem_wdata and the index are 0.
- All outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.
- State machine:
  - IDLE: start=1 captures src/dst/len, sets index=0 and clears error.
    - If len==0, go to DONE; otherwise go to READ.
    - start is ignored in every other state.
  - READ: mem_enable=1, mem_write=0, mem_addr=src+index.
    - On an edge with mem_ready==1: latch mem_rdata into the word buffer and go to WRITE.
    - Otherwise stay in READ (stall).
  - WRITE: mem_enable=1, mem_write=1, mem_addr=dst+index, mem_wdata=buffer.
    - On an edge with mem_ready==1: if index==len-1 go to DONE; otherwise index++ and go to READ.
    - Otherwise hold all outputs (stall).
  - DONE: done=1 for exactly one cycle, mem_enable=0, then go to IDLE.
- Latency: with ready always 1, a copy takes 2 cycles per word.
  - start is sampled at edge E0.
  - READ of word 0 occupies the cycle after E0.
  - done is high in the cycle after edge E0+2*len.
  - For len=0, done is high in the cycle after E0.
- Address arithmetic is modulo 2^DATA_WIDTH; src+index wraps silently.
- Overlapping regions are copied forward with no overlap correction.
- mem_enable is 0 in IDLE and DONE; mem_write is never 1 unless mem_enable is 1.
- Reset mid-copy: the next edge returns to IDLE with the port released.
  - No done pulse is produced.
  - A write already completed to memory is not undone.
- start and rst_in asserted together: reset wins.

Optional Feature:
- Macro: MEM_DMA_TIMEOUT_EN.
- With the macro defined:
  - A wait counter resets on every entry to READ or WRITE and on every ready==1 edge.
  - If it reaches TIMEOUT_CYCLES while in READ or WRITE, the copy aborts: error=1, go to DONE (done pulses), and the remaining words are skipped.
- Without the macro: there is no counter, error is tied to 0, and the block waits on ready indefinitely.

Test Plan:
- Single copy: memory preloaded with 0x11,0x22,0x33,0x44 at 0x10..0x13, ready tied 1, start with src=0x10, dst=0x40, len=4.
  - Required: 0x40..0x43 hold 0x11..0x44.
  - busy is high for 8 cycles; done pulses once, 9 cycles after the start edge; error=0.
- Zero length: start with len=0.
  - Required: mem_enable is never asserted; done pulses in the cycle after the start edge; busy stays 0.
- Stalls: ready held 0 for 3 cycles in the first READ and 2 cycles in the first WRITE, len=2.
  - Required: mem_addr and mem_wdata are stable during each stall; copied data is correct; done comes 5 cycles later than the no-stall case.
- start pulsed again mid-copy with different addresses.
  - Required: it is ignored; the original copy completes unchanged; only one done pulse.
- Reset mid-copy: rst_in asserted during the WRITE of word 1 of 4.
  - Required: the next cycle has mem_enable=0, busy=0 and no done pulse.
  - A fresh start after reset completes normally.
- With MEM_DMA_TIMEOUT_EN and TIMEOUT_CYCLES=8: ready held 0 forever after start.
  - Required: error=1 and a done pulse within 10 cycles of the start edge; mem_enable=0 afterwards.
  - The next start clears error.
